// File: rtl/key_event_pkg.sv
// Shared key indices, repeat states, default timing and helpers for key_event_gen.
package key_event_pkg;

    localparam int NKEY = 4;

    typedef enum logic [1:0] {
        K_DOWN   = 2'd0,
        K_UP     = 2'd1,
        K_BACK   = 2'd2,
        K_SELECT = 2'd3
    } key_idx_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_RATE
    } rep_state_e;

    localparam int DEF_DEBOUNCE_CYC     = 60000;
    localparam int DEF_REPEAT_DELAY_CYC = 1500000;
    localparam int DEF_REPEAT_RATE_CYC  = 300000;

    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction

    // One-hot of the highest set request bit; select(3) outranks down(0).
    function automatic logic [NKEY-1:0] prio_pick(input logic [NKEY-1:0] req);
        prio_pick = '0;
        for (int i = 0; i < NKEY; i++) begin
            if (req[i]) begin
                prio_pick    = '0;
                prio_pick[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key 2-flop synchroniser, stability counter, debounced level, arming and rise strobe.
import key_event_pkg::*;

module key_debounce #(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic held,
    output logic rise
);
    localparam int CW = cnt_w(DEBOUNCE_CYC);

    logic [1:0]    sync_n;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          level;

    assign level = ~sync_n[1];

    // The sync flops reset to "pressed" so a key held through reset never
    // looks released on the way out of reset and cannot arm early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_n <= 2'b00;
            cnt    <= '0;
            held   <= 1'b0;
            armed  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_n <= {sync_n[0], key_n};
            rise   <= 1'b0;
            if (!held && !level)
                armed <= 1'b1;
            if (level != held) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    held <= level;
                    cnt  <= '0;
                    rise <= level & armed;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Debounced one-pulse-per-cycle key event generator with a priority queue.
// Define KEY_AUTO_REPEAT_EN to add hold-to-repeat on the up and down keys.
import key_event_pkg::*;

module key_event_gen #(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NKEY-1:0] i_key_n,
    output logic [NKEY-1:0] o_pulse,
    output logic [NKEY-1:0] o_held,
    output logic            o_pending
);
    logic [NKEY-1:0] held;
    logic [NKEY-1:0] rise;
    logic [NKEY-1:0] rep;
    logic [NKEY-1:0] pend;
    logic [NKEY-1:0] pend_all;
    logic [NKEY-1:0] sel;

    if (DEBOUNCE_CYC < 3 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_cfg
        $error("key_event_gen: DEBOUNCE_CYC must be >= 3 and REPEAT_* >= 1");
    end

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (i_clk),
            .rst   (i_rst),
            .key_n (i_key_n[k]),
            .held  (held[k]),
            .rise  (rise[k])
        );
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RCW  = cnt_w(RMAX);

    for (genvar k = int'(K_DOWN); k <= int'(K_UP); k++) begin : g_rep
        rep_state_e     state, state_nxt;
        logic [RCW-1:0] cnt, cnt_nxt;
        logic           rep_k;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state <= R_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt + RCW'(1);
            rep_k     = 1'b0;
            case (state)
                R_IDLE: begin
                    cnt_nxt = '0;
                    if (rise[k])
                        state_nxt = R_DELAY;
                end
                R_DELAY: begin
                    if (cnt == RCW'(REPEAT_DELAY_CYC - 1)) begin
                        rep_k     = 1'b1;
                        state_nxt = R_RATE;
                        cnt_nxt   = '0;
                    end
                end
                R_RATE: begin
                    if (cnt == RCW'(REPEAT_RATE_CYC - 1)) begin
                        rep_k   = 1'b1;
                        cnt_nxt = '0;
                    end
                end
                default: state_nxt = R_IDLE;
            endcase
            // Release overrides everything, so no repeat slips out after it.
            if (!held[k]) begin
                state_nxt = R_IDLE;
                cnt_nxt   = '0;
                rep_k     = 1'b0;
            end
        end

        assign rep[k] = rep_k;
    end
    assign rep[NKEY-1:int'(K_UP)+1] = '0;
`else
    assign rep = '0;
`endif

    // New events join the queue combinationally so an idle queue emits one cycle after the rise.
    assign pend_all = pend | rise | rep;
    assign sel      = prio_pick(pend_all);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend      <= '0;
            o_pulse   <= '0;
            o_pending <= 1'b0;
        end else begin
            pend      <= pend_all & ~sel;
            o_pulse   <= sel;
            o_pending <= |(pend_all & ~sel);
        end
    end

    assign o_held = held;

endmodule
